// File: rtl/watch_pkg.sv
// Shared watch definitions: alarm FSM state encoding and time-of-day limits.
// The watch counter and the alarm stage both import this package.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam int unsigned C_SEC_MAX  = 59;
  localparam int unsigned C_MIN_MAX  = 59;
  localparam int unsigned C_HOUR_MAX = 23;

endpackage

// File: rtl/sec_tick_det.sv
// Change detector on the seconds bus: o_tick is high in any cycle where i_sec
// differs from its value in the previous cycle.
module sec_tick_det #(
  parameter int unsigned P_SEC_BIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P_SEC_BIT-1:0] i_sec,
  output logic                 o_tick
);

  logic [P_SEC_BIT-1:0] prev_sec_d, prev_sec_q;

  always_comb begin
    prev_sec_d = i_sec;
    o_tick     = (i_sec != prev_sec_q);
  end

  always_ff @(posedge clk) begin
    if (reset) prev_sec_q <= '0;
    else       prev_sec_q <= prev_sec_d;
  end

endmodule

// File: rtl/watch_alarm.sv
// Alarm stage behind the watch time counter: programmable alarm time, ring/snooze
// FSM with per-state second counter, registered ring request.
module watch_alarm
  import watch_pkg::*;
#(
  parameter int unsigned P_SEC_BIT    = 6,
  parameter int unsigned P_MIN_BIT    = 6,
  parameter int unsigned P_HOUR_BIT   = 5,
  parameter int unsigned P_RING_SEC   = 60,
  parameter int unsigned P_SNOOZE_SEC = 300,
  parameter int unsigned P_MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic                  i_alarm_en,
  input  logic                  i_set_valid,
  input  logic [P_HOUR_BIT-1:0] i_set_hour,
  input  logic [P_MIN_BIT-1:0]  i_set_min,
  input  logic                  i_snooze,
  input  logic                  i_stop,
  output logic                  o_ring,
  output logic [1:0]            o_state,
  output logic [1:0]            o_snooze_cnt,
  output logic [P_HOUR_BIT-1:0] o_alarm_hour,
  output logic [P_MIN_BIT-1:0]  o_alarm_min,
  output logic                  o_set_err
);

  localparam logic [8:0] RING_LAST   = 9'(P_RING_SEC - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(P_SNOOZE_SEC - 1);
  localparam logic [1:0] SNOOZE_MAX  = 2'(P_MAX_SNOOZE);

  state_e                state_d, state_q;
  logic [8:0]            cnt_d, cnt_q;
  logic [1:0]            snz_d, snz_q;
  logic [P_HOUR_BIT-1:0] hour_d, hour_q;
  logic [P_MIN_BIT-1:0]  min_d, min_q;
  logic                  set_err_d, set_err_q;
  logic                  ring_d, ring_q;
  logic                  sec_tick, trigger, set_ok;

  sec_tick_det #(.P_SEC_BIT(P_SEC_BIT)) u_sec_tick_det (
    .clk    (clk),
    .reset  (reset),
    .i_sec  (i_sec),
    .o_tick (sec_tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snz_d     = snz_q;
    hour_d    = hour_q;
    min_d     = min_q;
    set_err_d = 1'b0;
    // Trigger uses the stored alarm time, so a same-cycle set compares against the old value.
    trigger = sec_tick && (i_sec == '0) && (i_min == min_q) && (i_hour == hour_q);
    set_ok  = (i_set_hour <= P_HOUR_BIT'(C_HOUR_MAX)) && (i_set_min <= P_MIN_BIT'(C_MIN_MAX));

    if (i_set_valid) begin
      if (set_ok) begin
        hour_d = i_set_hour;
        min_d  = i_set_min;
      end else begin
        set_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_alarm_en && trigger) begin
          state_d = ST_RINGING;
          cnt_d   = '0;
          snz_d   = '0;
        end
      end
      ST_RINGING: begin
        if (!i_alarm_en || i_stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_snooze && (snz_q < SNOOZE_MAX)) begin
          state_d = ST_SNOOZE;
          cnt_d   = '0;
          snz_d   = snz_q + 2'd1;
        end else if (sec_tick) begin
          if (cnt_q == RING_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (!i_alarm_en || i_stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sec_tick) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ring_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      snz_q     <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      set_err_q <= 1'b0;
      ring_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snz_q     <= snz_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      set_err_q <= set_err_d;
      ring_q    <= ring_d;
    end
  end

  assign o_ring       = ring_q;
  assign o_state      = state_q;
  assign o_snooze_cnt = snz_q;
  assign o_alarm_hour = hour_q;
  assign o_alarm_min  = min_q;
  assign o_set_err    = set_err_q;

endmodule

// File: tb/tb_watch_alarm.sv
// Directed bench for watch_alarm: trigger, timeout, snooze limit, set checks,
// stop/snooze priority, reset mid-snooze and midnight wrap.
module tb_watch_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] i_sec, i_min, i_set_min;
  logic [4:0] i_hour, i_set_hour;
  logic       i_alarm_en, i_set_valid, i_snooze, i_stop;
  logic       o_ring, o_set_err;
  logic [1:0] o_state, o_snooze_cnt;
  logic [4:0] o_alarm_hour;
  logic [5:0] o_alarm_min;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  watch_alarm dut (
    .clk          (clk),
    .reset        (reset),
    .i_sec        (i_sec),
    .i_min        (i_min),
    .i_hour       (i_hour),
    .i_alarm_en   (i_alarm_en),
    .i_set_valid  (i_set_valid),
    .i_set_hour   (i_set_hour),
    .i_set_min    (i_set_min),
    .i_snooze     (i_snooze),
    .i_stop       (i_stop),
    .o_ring       (o_ring),
    .o_state      (o_state),
    .o_snooze_cnt (o_snooze_cnt),
    .o_alarm_hour (o_alarm_hour),
    .o_alarm_min  (o_alarm_min),
    .o_set_err    (o_set_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    i_hour = h; i_min = m; i_sec = s;
    step();
  endtask

  // n seconds changes, never landing on 0 so no trigger can occur
  task automatic sec_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_sec = (i_sec >= 6'd59) ? 6'd1 : i_sec + 6'd1;
      step();
    end
  endtask

  task automatic pulse_set(input logic [4:0] h, input logic [5:0] m);
    i_set_valid = 1'b1; i_set_hour = h; i_set_min = m;
    step();
    i_set_valid = 1'b0;
  endtask

  task automatic pulse_snooze();
    i_snooze = 1'b1;
    step();
    i_snooze = 1'b0;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic ring, input logic [1:0] snz);
    chk({tag, "_state"}, 32'(o_state), 32'(st));
    chk({tag, "_ring"},  32'(o_ring), 32'(ring));
    chk({tag, "_snz"},   32'(o_snooze_cnt), 32'(snz));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_st(tag, 2'd0, 1'b0, 2'd0);
    chk({tag, "_hour"}, 32'(o_alarm_hour), 0);
    chk({tag, "_min"},  32'(o_alarm_min), 0);
    chk({tag, "_err"},  32'(o_set_err), 0);
  endtask

  initial begin
    reset = 1'b1;
    i_sec = '0; i_min = '0; i_hour = '0;
    i_alarm_en = 1'b0; i_set_valid = 1'b0; i_set_hour = '0; i_set_min = '0;
    i_snooze = 1'b0; i_stop = 1'b0;
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Program 07:30 and trigger on 07:29:59 -> 07:30:00
    set_time(5'd7, 6'd29, 6'd59);
    pulse_set(5'd7, 6'd30);
    chk("set_hour", 32'(o_alarm_hour), 7);
    chk("set_min",  32'(o_alarm_min), 30);
    chk("set_ok_err", 32'(o_set_err), 0);
    i_alarm_en = 1'b1;
    step();
    chk("pre_trig_ring", 32'(o_ring), 0);
    set_time(5'd7, 6'd30, 6'd0);
    chk_st("trig", 2'd1, 1'b1, 2'd0);

    // Static time is not a tick; timeout after exactly 60 ticks
    repeat (100) step();
    chk_st("static", 2'd1, 1'b1, 2'd0);
    sec_ticks(59);
    chk("tick59_ring", 32'(o_ring), 1);
    sec_ticks(1);
    chk_st("timeout", 2'd0, 1'b0, 2'd0);

    // Retrigger, then three full snooze rounds
    set_time(5'd7, 6'd30, 6'd0);
    chk_st("retrig", 2'd1, 1'b1, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      pulse_snooze();
      chk_st("snooze", 2'd2, 1'b0, 2'(k));
      sec_ticks(299);
      chk("snooze_hold", 32'(o_state), 2);
      sec_ticks(1);
      chk_st("rering", 2'd1, 1'b1, 2'(k));
    end
    pulse_snooze();
    chk_st("snooze_limit", 2'd1, 1'b1, 2'd3);

    // Stop beats snooze; trigger clears the snooze count
    i_stop = 1'b1; i_snooze = 1'b1;
    step();
    i_stop = 1'b0; i_snooze = 1'b0;
    chk_st("stop_lim", 2'd0, 1'b0, 2'd3);
    set_time(5'd7, 6'd30, 6'd0);
    chk_st("trig3", 2'd1, 1'b1, 2'd0);
    i_stop = 1'b1; i_snooze = 1'b1;
    step();
    i_stop = 1'b0; i_snooze = 1'b0;
    chk_st("stop_snz", 2'd0, 1'b0, 2'd0);

    // Rejected and accepted set requests
    pulse_set(5'd24, 6'd10);
    chk("err_pulse", 32'(o_set_err), 1);
    chk("err_hour", 32'(o_alarm_hour), 7);
    chk("err_min",  32'(o_alarm_min), 30);
    step();
    chk("err_clear", 32'(o_set_err), 0);
    pulse_set(5'd7, 6'd60);
    chk("err_min60", 32'(o_set_err), 1);
    chk("err_min60_keep", 32'(o_alarm_min), 30);
    pulse_set(5'd23, 6'd59);
    chk("set2359_err", 32'(o_set_err), 0);
    chk("set2359_hour", 32'(o_alarm_hour), 23);
    chk("set2359_min",  32'(o_alarm_min), 59);

    // Set in the trigger cycle: old time still matches
    set_time(5'd23, 6'd58, 6'd59);
    i_set_valid = 1'b1; i_set_hour = 5'd8; i_set_min = 6'd0;
    set_time(5'd23, 6'd59, 6'd0);
    i_set_valid = 1'b0;
    chk_st("set_vs_trig", 2'd1, 1'b1, 2'd0);
    chk("set_vs_trig_hour", 32'(o_alarm_hour), 8);

    // Dropping enable ends ringing
    i_alarm_en = 1'b0;
    step();
    chk_st("en_off", 2'd0, 1'b0, 2'd0);
    i_alarm_en = 1'b1;

    // Reset during SNOOZE
    set_time(5'd7, 6'd59, 6'd59);
    set_time(5'd8, 6'd0, 6'd0);
    chk("trig8", 32'(o_ring), 1);
    pulse_snooze();
    chk("snz8", 32'(o_state), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_snz");
    set_time(5'd0, 6'd0, 6'd0);
    repeat (3) step();
    chk_st("no_static_trig", 2'd0, 1'b0, 2'd0);

    // Midnight wrap triggers the reset alarm time 00:00
    set_time(5'd23, 6'd59, 6'd59);
    chk("pre_midnight", 32'(o_ring), 0);
    set_time(5'd0, 6'd0, 6'd0);
    chk_st("midnight", 2'd1, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/watch_alarm.md
# watch_alarm

Alarm stage directly downstream of the watch time counter. It consumes the registered hour/minute/second outputs and stores a programmable alarm time. It runs a ring/snooze state machine and drives a ring request to the buzzer/LED driver. Seconds are counted by detecting changes on the incoming seconds value, so the block needs no tick from the timebase.

## Interface
- P_SEC_BIT, 6, width of seconds input
- P_MIN_BIT, 6, width of minutes input and alarm minute
- P_HOUR_BIT, 5, width of hours input and alarm hour
- P_RING_SEC, 60, seconds RINGING lasts before auto-stop (1..511)
- P_SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing (1..511)
- P_MAX_SNOOZE, 3, maximum snoozes per alarm event (0..3)
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- i_sec  input  P_SEC_BIT  current seconds, 0..59, from the watch counter
- i_min  input  P_MIN_BIT  current minutes, 0..59
- i_hour  input  P_HOUR_BIT  current hours, 0..23
- i_alarm_en  input  1  level; alarm armed when high
- i_set_valid  input  1  one-cycle strobe to load a new alarm time
- i_set_hour  input  P_HOUR_BIT  alarm hour to load
- i_set_min  input  P_MIN_BIT  alarm minute to load
- i_snooze  input  1  one-cycle snooze request
- i_stop  input  1  one-cycle stop/dismiss request
- o_ring  output  1  high while in RINGING
- o_state  output  2  current state encoding
- o_snooze_cnt  output  2  snoozes used in the current alarm event
- o_alarm_hour  output  P_HOUR_BIT  stored alarm hour
- o_alarm_min  output  P_MIN_BIT  stored alarm minute
- o_set_err  output  1  one-cycle pulse when a set request is rejected

## Operation
- **Second tick.**
  - r_prev_sec holds i_sec registered every cycle.
  - sec_tick = (i_sec != r_prev_sec).
- **Trigger condition.** All of the following in the same cycle:
  - sec_tick
  - i_sec == 0
  - i_min == o_alarm_min
  - i_hour == o_alarm_hour
  - A static time match that is present without a seconds change never triggers.
- **States.** IDLE=0, RINGING=1, SNOOZE=2. Encoding 3 is unused; if reached, go to IDLE next cycle.
- **Priority within a cycle:** reset > !i_alarm_en > i_stop > i_snooze > timeout/trigger.
- **IDLE.**
  - Trigger && i_alarm_en → RINGING, sec counter := 0, o_snooze_cnt := 0.
- **RINGING.**
  - !i_alarm_en or i_stop → IDLE.
  - i_snooze && o_snooze_cnt < P_MAX_SNOOZE → SNOOZE, o_snooze_cnt +1, counter := 0.
  - i_snooze at the limit is ignored.
  - On each sec_tick the counter increments; a tick while counter == P_RING_SEC-1 → IDLE.
- **SNOOZE.**
  - !i_alarm_en or i_stop → IDLE.
  - A tick while counter == P_SNOOZE_SEC-1 → RINGING, counter := 0.
  - i_snooze is ignored.
- **Trigger outside IDLE.** Ignored; there is no re-arm or queueing.
- **Set request.**
  - When i_set_valid is high with i_set_hour < 24 and i_set_min < 60, load the alarm registers.
  - When either value is out of range, keep the old values and pulse o_set_err.
  - A set request never changes the state or counters.
- **Counter.** 9 bits, cleared on every state entry, never wraps.

## Timing
- **Reset values:**
  - o_state = IDLE, o_ring = 0
  - o_snooze_cnt = 0, counter = 0
  - o_alarm_hour = 0, o_alarm_min = 0
  - o_set_err = 0, r_prev_sec = 0
- **Latency.** All outputs are registered; any input condition sampled at edge N is visible after edge N+1, i.e. 1-cycle latency.
- **Ring end.** o_ring falls one cycle after i_stop, i_snooze, !i_alarm_en, or the timeout tick.
- **Alarm registers.** Updated one cycle after a valid i_set_valid. o_set_err is high for exactly one cycle.
- **Set vs. trigger.** A set request in the same cycle as a trigger compares against the old alarm time.
- **Reset mid-RINGING/SNOOZE.** Returns to IDLE next cycle and the alarm time is lost.
- **Midnight wrap** (23:59:59 → 0:00:00) is an ordinary tick; an alarm at 0:00 triggers on it.

## Structure
- **Package watch_pkg:**
  - state constants ST_IDLE/ST_RINGING/ST_SNOOZE
  - limits C_SEC_MAX=59, C_MIN_MAX=59, C_HOUR_MAX=23
  - shared with the watch counter
- **Sub-module sec_tick_det:** a change detector on the seconds bus producing sec_tick. Everything else stays in watch_alarm.

## Test plan
- Set 07:30, i_alarm_en=1, drive time 07:29:59 → 07:30:00 → o_ring=1 one cycle after the change, o_snooze_cnt=0.
- Ringing, hold time with no seconds change for 100 cycles, then 60 second changes → o_ring falls after the 60th tick, o_state=0.
- Ringing, i_snooze ×3 separated by P_SNOOZE_SEC ticks each:
  - three SNOOZE→RINGING cycles, o_snooze_cnt reaches 3
  - a 4th i_snooze is ignored, and o_ring stays 1
- i_set_valid with hour=24, min=10 → o_set_err single-cycle pulse, alarm stays 07:30; then 23:59 is accepted.
- i_stop and i_snooze in the same cycle while RINGING → IDLE, o_snooze_cnt unchanged.
- Reset during SNOOZE → outputs at reset values next cycle; a following 00:00:00 time with no seconds change produces no trigger.
